// File: rtl/ocp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ocp_pkg
// Brief    : Shared OCP encodings (MCmd, SResp), request status and slave FSM
//            state types.
// Revision : 1.0  initial release
// ============================================================================
package ocp_pkg;

    localparam logic [2:0] c_mcmd_idle  = 3'b000;
    localparam logic [2:0] c_mcmd_write = 3'b001;
    localparam logic [2:0] c_mcmd_read  = 3'b010;
    localparam logic [2:0] c_mcmd_wrc   = 3'b110;

    localparam logic [1:0] c_sresp_null = 2'b00;
    localparam logic [1:0] c_sresp_dva  = 2'b01;
    localparam logic [1:0] c_sresp_fail = 2'b10;
    localparam logic [1:0] c_sresp_err  = 2'b11;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_FAIL = 2'd1,
        ST_ERR  = 2'd2
    } ocp_status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } ocp_state_e;

    function automatic logic ocp_cmd_supported(input logic [2:0] cmd);
        return (cmd == c_mcmd_write) || (cmd == c_mcmd_read) || (cmd == c_mcmd_wrc);
    endfunction

    function automatic logic [1:0] ocp_status_to_sresp(input ocp_status_e st);
        logic [1:0] resp;
        case (st)
            ST_OK:   resp = c_sresp_dva;
            ST_FAIL: resp = c_sresp_fail;
            default: resp = c_sresp_err;
        endcase
        return resp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ocp_slave_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : ocp_slave_mem_array
// Brief    : DEPTH x 32 synchronous RAM with byte-lane write enables and a
//            registered read port.
// Revision : 1.0  initial release
// ============================================================================
module ocp_slave_mem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] w_wmask;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign w_wmask[8*k +: 8] = {8{be[k]}};
    end

    // Read port samples every cycle; the caller steers ridx so the value
    // captured at the accept edge stays stable until the response.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[widx] <= (r_mem[widx] & ~w_wmask) | (wdata & w_wmask);
        end
        rdata <= r_mem[ridx];
    end

endmodule
`default_nettype wire

// File: rtl/ocp_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : ocp_slave_mem
// Brief    : Single-thread OCP slave memory with programmable accept wait and
//            response latency. OCP_WRITE_RESP_EN makes writes non-posted (DVA).
// Revision : 1.0  initial release
// ============================================================================
module ocp_slave_mem
    import ocp_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned ACCEPT_WAIT = 0,
    parameter int unsigned RESP_LAT    = 1
) (
    input  logic              Clk_i,
    input  logic              MReset_ni,
    input  logic [2:0]        MCmd_i,
    input  logic [ADDR_W-1:0] MAddr_i,
    input  logic [3:0]        MByteEn_i,
    input  logic [31:0]       MData_i,
    output logic              SCmdAccept_o,
    output logic [1:0]        SResp_o,
    output logic [31:0]       SData_o
);

    localparam int unsigned c_idx_w       = $clog2(DEPTH);
    localparam int unsigned c_widx_w      = ADDR_W - 2;
    localparam logic [3:0]  c_accept_wait = 4'(ACCEPT_WAIT);
    localparam logic [3:0]  c_resp_lat_m1 = 4'(RESP_LAT - 1);

    ocp_state_e          r_state;
    ocp_state_e          w_state_nxt;
    logic [3:0]          r_wait_cnt;
    logic [3:0]          w_wait_nxt;
    logic [3:0]          r_lat_cnt;
    logic [3:0]          w_lat_nxt;

    logic [2:0]          r_cmd;
    ocp_status_e         r_status;
    logic [c_idx_w-1:0]  r_idx;

    logic [c_widx_w-1:0] w_word_idx;
    logic                w_idx_in_range;
    ocp_status_e         w_status;
    logic                w_accept;
    logic                w_fire;
    logic                w_write_ok;
    logic                w_we;
    logic                w_need_resp;
    logic [c_idx_w-1:0]  w_ridx;
    logic [31:0]         w_rdata;

    assign w_word_idx     = MAddr_i[ADDR_W-1:2];
    assign w_idx_in_range = (32'(w_word_idx) < DEPTH);

    // Accept is a pure register decode so MCmd_i never reaches SCmdAccept_o.
    assign w_accept     = (r_state == S_IDLE) && (r_wait_cnt == c_accept_wait);
    assign w_fire       = MReset_ni && w_accept && (MCmd_i != c_mcmd_idle);
    assign SCmdAccept_o = MReset_ni && w_accept;

    always_comb begin
        w_status = ST_OK;
        if (!ocp_cmd_supported(MCmd_i) || (MAddr_i[1:0] != 2'b00) || !w_idx_in_range) begin
            w_status = ST_ERR;
        end else if (MCmd_i == c_mcmd_wrc) begin
            w_status = ST_FAIL;
        end
    end

    assign w_write_ok = (w_status == ST_OK) && (MCmd_i == c_mcmd_write);
    assign w_we       = w_fire && w_write_ok;

`ifdef OCP_WRITE_RESP_EN
    assign w_need_resp = 1'b1;
`else
    assign w_need_resp = !w_write_ok;
`endif

    always_ff @(posedge Clk_i) begin
        if (!MReset_ni) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
            r_lat_cnt  <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_lat_cnt  <= w_lat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_lat_nxt   = r_lat_cnt;
        case (r_state)
            S_IDLE: begin
                if (MCmd_i == c_mcmd_idle) begin
                    w_wait_nxt = 4'd0;
                end else if (w_accept) begin
                    w_wait_nxt = 4'd0;
                    w_lat_nxt  = 4'd1;
                    if (w_need_resp) begin
                        w_state_nxt = (c_resp_lat_m1 == 4'd0) ? S_RESP : S_BUSY;
                    end
                end else if (r_wait_cnt < c_accept_wait) begin
                    w_wait_nxt = r_wait_cnt + 4'd1;
                end
            end
            S_BUSY: begin
                if (r_lat_cnt >= c_resp_lat_m1) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_lat_nxt = r_lat_cnt + 4'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_lat_nxt   = 4'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_lat_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (!MReset_ni) begin
            r_cmd    <= c_mcmd_idle;
            r_status <= ST_OK;
            r_idx    <= '0;
        end else if (w_fire) begin
            r_cmd    <= MCmd_i;
            r_status <= w_status;
            r_idx    <= w_word_idx[c_idx_w-1:0];
        end
    end

    // Out-of-range indices are truncated here but never written or returned.
    assign w_ridx = (r_state == S_IDLE) ? w_word_idx[c_idx_w-1:0] : r_idx;

    ocp_slave_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (c_idx_w)
    ) u_array (
        .clk   (Clk_i),
        .we    (w_we),
        .be    (MByteEn_i),
        .widx  (w_word_idx[c_idx_w-1:0]),
        .wdata (MData_i),
        .ridx  (w_ridx),
        .rdata (w_rdata)
    );

    always_comb begin
        SResp_o = c_sresp_null;
        SData_o = 32'h0;
        if (MReset_ni && (r_state == S_RESP)) begin
            SResp_o = ocp_status_to_sresp(r_status);
            if ((r_status == ST_OK) && (r_cmd == c_mcmd_read)) begin
                SData_o = w_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ocp_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_ocp_slave_mem
// Brief    : Scoreboard bench for ocp_slave_mem (ACCEPT_WAIT=3, RESP_LAT=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_ocp_slave_mem;

    localparam int AW     = 3;
    localparam int RL     = 2;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_WRITE = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [2:0] CMD_WRC   = 3'b110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  mcmd;
    logic [15:0] maddr;
    logic [3:0]  mbe;
    logic [31:0] mdata;
    logic        acc;
    logic [1:0]  sresp;
    logic [31:0] sdata;

    always #5 clk = ~clk;

    ocp_slave_mem #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .ACCEPT_WAIT (AW),
        .RESP_LAT    (RL)
    ) dut (
        .Clk_i        (clk),
        .MReset_ni    (rst_n),
        .MCmd_i       (mcmd),
        .MAddr_i      (maddr),
        .MByteEn_i    (mbe),
        .MData_i      (mdata),
        .SCmdAccept_o (acc),
        .SResp_o      (sresp),
        .SData_o      (sdata)
    );

    typedef struct {
        int          due;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [int];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [2:0] c, input logic [15:0] a);
        if (!(c == CMD_WRITE || c == CMD_READ || c == CMD_WRC)) return 2'b11;
        if (a[1:0] != 2'b00) return 2'b11;
        if (int'(a[15:2]) >= DEPTH) return 2'b11;
        if (c == CMD_WRC) return 2'b10;
        return 2'b01;
    endfunction

    function automatic void model_accept();
        exp_t        e;
        logic [1:0]  r;
        logic [31:0] w;
        int          idx;
        r      = exp_resp(mcmd, maddr);
        idx    = int'(maddr[15:2]);
        e.due  = cyc + RL;
        e.resp = r;
        e.data = 32'h0;
        if (r == 2'b01 && mcmd == CMD_WRITE) begin
            w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (mbe[k]) w[8*k +: 8] = mdata[8*k +: 8];
            end
            mem_m[idx] = w;
`ifdef OCP_WRITE_RESP_EN
            sb.push_back(e);
`endif
        end else begin
            if (r == 2'b01) e.data = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            sb.push_back(e);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            check_val("rst_accept", {31'h0, acc}, 32'h0);
            check_val("rst_sresp", {30'h0, sresp}, 32'h0);
            check_val("rst_sdata", sdata, 32'h0);
        end else begin
            if (sb.size() != 0) begin
                check_val("accept_busy", {31'h0, acc}, 32'h0);
                if (sb[0].due == cyc) begin
                    check_val("sresp", {30'h0, sresp}, {30'h0, sb[0].resp});
                    check_val("sdata", sdata, sb[0].data);
                    void'(sb.pop_front());
                end else begin
                    check_val("sresp_wait", {30'h0, sresp}, 32'h0);
                    check_val("sdata_wait", sdata, 32'h0);
                end
            end else begin
                check_val("sresp_idle", {30'h0, sresp}, 32'h0);
                check_val("sdata_idle", sdata, 32'h0);
            end
            if (acc && mcmd != CMD_IDLE) model_accept();
        end
    end

    task automatic do_req(input logic [2:0] cmd, input logic [15:0] addr, input logic [3:0] be,
                          input logic [31:0] data, input bit rel_rst);
        int n;
        n = 0;
        for (int g = 0; g < 50 && sb.size() != 0; g++) @(negedge clk);
        check_val("drain", sb.size(), 32'h0);
        @(posedge clk);
        #1;
        mcmd  = cmd;
        maddr = addr;
        mbe   = be;
        mdata = data;
        if (rel_rst) rst_n = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!acc && n < 40);
        check_val("accept_wait", n, AW + 1);
        @(posedge clk);
        #1;
        mcmd = CMD_IDLE;
    endtask

    initial begin
        rst_n = 1'b0;
        mcmd  = CMD_READ;
        maddr = 16'h0002;
        mbe   = 4'h0;
        mdata = 32'h0;
        repeat (16) @(posedge clk);
        // Misaligned read straight out of reset: first accept after release.
        do_req(CMD_READ, 16'h0002, 4'h0, 32'h0, 1'b1);

        do_req(CMD_WRITE, 16'h0010, 4'hF, 32'hDEADBEEF, 1'b0);
        do_req(CMD_READ,  16'h0010, 4'h0, 32'h0, 1'b0);
        do_req(CMD_WRITE, 16'h0010, 4'h5, 32'h11223344, 1'b0);
        do_req(CMD_READ,  16'h0010, 4'h0, 32'h0, 1'b0);
        do_req(CMD_WRITE, 16'h0020, 4'hF, 32'hCAFEF00D, 1'b0);
        do_req(CMD_WRITE, 16'h0000, 4'hF, 32'h01234567, 1'b0);

        do_req(CMD_WRITE, 16'h0012, 4'hF, 32'hBAD0BAD0, 1'b0);
        do_req(CMD_READ,  16'h0010, 4'h0, 32'h0, 1'b0);
        do_req(CMD_READ,  16'h0012, 4'h0, 32'h0, 1'b0);
        do_req(3'b011,    16'h0020, 4'hF, 32'hBAD1BAD1, 1'b0);
        do_req(CMD_READ,  16'h0020, 4'h0, 32'h0, 1'b0);
        do_req(CMD_WRC,   16'h0020, 4'hF, 32'hBAD2BAD2, 1'b0);
        do_req(CMD_READ,  16'h0020, 4'h0, 32'h0, 1'b0);
        do_req(CMD_WRITE, 16'h0400, 4'hF, 32'hBAD3BAD3, 1'b0);
        do_req(CMD_READ,  16'h0000, 4'h0, 32'h0, 1'b0);
        do_req(CMD_READ,  16'h0400, 4'h0, 32'h0, 1'b0);

        do_req(CMD_WRITE, 16'h0010, 4'h0, 32'hFFFFFFFF, 1'b0);
        do_req(CMD_READ,  16'h0010, 4'h0, 32'h0, 1'b0);
        do_req(CMD_WRITE, 16'h03FC, 4'hF, 32'hA5A55A5A, 1'b0);
        do_req(CMD_READ,  16'h03FC, 4'h0, 32'h0, 1'b0);

        // Reset while the read is in S_BUSY: its response must never appear.
        do_req(CMD_READ, 16'h0020, 4'h0, 32'h0, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        do_req(CMD_READ, 16'h0010, 4'h0, 32'h0, 1'b0);
        do_req(CMD_READ, 16'h0020, 4'h0, 32'h0, 1'b0);

        repeat (6) @(negedge clk);
        check_val("sb_empty", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
